// File: rtl/map_scanner_if.sv
// Raster/map coordinate bus between map_scanner (source) and the map renderer.
// Camera inputs ride on the same bundle so the camera/physics side drives them here.
interface map_scanner_if #(
  parameter int unsigned PHY_WIDTH = 14
);
  logic [PHY_WIDTH-1:0] cam_x;
  logic [PHY_WIDTH-1:0] cam_y;
  logic                 hsync;
  logic                 vsync;
  logic                 video_on;
  logic [PHY_WIDTH-1:0] map_x;
  logic [PHY_WIDTH-1:0] map_y;
  logic                 map_on;
  logic                 pix_tick;
  logic                 frame_start;

  modport master (
    input  cam_x, cam_y,
    output hsync, vsync, video_on, map_x, map_y, map_on, pix_tick, frame_start
  );

  modport slave (
    output cam_x, cam_y,
    input  hsync, vsync, video_on, map_x, map_y, map_on, pix_tick, frame_start
  );
endinterface

// File: rtl/map_scanner.sv
// VGA raster scanner that maps each pixel to world map coordinates via a per-frame camera latch.
// Optional macro MAP_Y_UP_EN: world y grows upward with the bottom screen row at cam_y.
module map_scanner #(
  parameter int unsigned PHY_WIDTH   = 14,
  parameter int unsigned MAP_WIDTH_X = 480,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  map_scanner_if.master bus
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned DW      = $clog2(CLK_DIV);
  localparam int unsigned PW      = PHY_WIDTH;
  localparam int unsigned PW1     = PHY_WIDTH + 1;

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [PW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          video_on_q, video_on_d, map_on_q, map_on_d;
  logic          pix_tick_q, pix_tick_d, frame_start_q, frame_start_d;
  logic [PW-1:0] map_x_q, map_x_d, map_y_q, map_y_d;

  logic          tick_c;
  logic          vid_c;
  logic          fs_c;
  logic [PW:0]   sum_x_c;

  // Divider, raster counters, per-pixel outputs and the frame-boundary camera latch.
  always_comb begin
    div_d         = div_q;
    h_d           = h_q;
    v_d           = v_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    map_on_d      = map_on_q;
    map_x_d       = map_x_q;
    map_y_d       = map_y_q;
    pix_tick_d    = 1'b0;
    frame_start_d = 1'b0;

    tick_c  = (div_q == DW'(CLK_DIV - 1));
    vid_c   = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    fs_c    = (h_q == '0) && (v_q == VW'(V_ACTIVE));
    // Extra carry bit keeps a wrapped x from ever comparing as on-map.
    sum_x_c = {1'b0, cx_q} + PW1'(h_q);

    if (tick_c) begin
      div_d = '0;
      if (h_q == HW'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end

      video_on_d = vid_c;
      hsync_d    = !((h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
      vsync_d    = !((v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
      map_x_d    = sum_x_c[PW-1:0];
`ifdef MAP_Y_UP_EN
      map_y_d    = cy_q + PW'(V_ACTIVE - 1) - PW'(v_q);
`else
      map_y_d    = cy_q + PW'(v_q);
`endif
      map_on_d      = vid_c && (sum_x_c < PW1'(MAP_WIDTH_X));
      pix_tick_d    = 1'b1;
      frame_start_d = fs_c;
      if (fs_c) begin
        cx_d = bus.cam_x;
        cy_d = bus.cam_y;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      cx_q          <= '0;
      cy_q          <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      map_on_q      <= 1'b0;
      map_x_q       <= '0;
      map_y_q       <= '0;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      map_on_q      <= map_on_d;
      map_x_q       <= map_x_d;
      map_y_q       <= map_y_d;
      pix_tick_q    <= pix_tick_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.video_on    = video_on_q;
  assign bus.map_on      = map_on_q;
  assign bus.map_x       = map_x_q;
  assign bus.map_y       = map_y_q;
  assign bus.pix_tick    = pix_tick_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_map_scanner.sv
// Randomized bench for map_scanner on a shrunken raster, against a pixel-index reference model.
module tb_map_scanner;
  localparam int PW  = 14;
  localparam int MWX = 12;
  localparam int CD  = 4;
  localparam int HA  = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA  = 10, VF = 1, VS = 2, VB = 2;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int MOD = 1 << PW;

  typedef struct packed {
    logic          video_on;
    logic          hsync;
    logic          vsync;
    logic          map_on;
    logic          frame_start;
    logic [PW-1:0] map_x;
    logic [PW-1:0] map_y;
  } exp_t;

  logic clk;
  logic rst_n;
  map_scanner_if #(.PHY_WIDTH(PW)) bus ();

  map_scanner #(
    .PHY_WIDTH(PW), .MAP_WIDTH_X(MWX), .CLK_DIV(CD),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk;
  int   n_pass;
  int   cyc;
  int   mcx, mcy;
  bit   last_tick;
  int   last_h, last_v;
  exp_t last_e;

  // Expected outputs of pixel number p (counted from reset) under camera (cx, cy).
  function automatic exp_t model(int p, int cx, int cy);
    exp_t e;
    int h = p % HT;
    int v = (p / HT) % VT;
    e.video_on    = (h < HA) && (v < VA);
    e.hsync       = !(h >= HA + HF && h < HA + HF + HS);
    e.vsync       = !(v >= VA + VF && v < VA + VF + VS);
    e.map_x       = PW'((cx + h) % MOD);
    e.map_on      = e.video_on && (cx + h < MWX);
    e.frame_start = (h == 0) && (v == VA);
`ifdef MAP_Y_UP_EN
    e.map_y       = PW'((cy + VA - 1 - v + MOD) % MOD);
`else
    e.map_y       = PW'((cy + v) % MOD);
`endif
    return e;
  endfunction

  // One clock of time plus the model's view of which pixel (if any) was just emitted.
  task automatic advance();
    int p;
    @(posedge clk);
    #1;
    cyc++;
    last_tick = (cyc % CD == 0);
    if (last_tick) begin
      p      = cyc / CD - 1;
      last_h = p % HT;
      last_v = (p / HT) % VT;
      last_e = model(p, mcx, mcy);
      if (last_e.frame_start) begin
        mcx = int'(bus.cam_x);
        mcy = int'(bus.cam_y);
      end
    end
  endtask

  task automatic advance_to(input int h, input int v);
    int guard = 0;
    do begin
      advance();
      guard++;
    end while (!(last_tick && last_h == h && last_v == v) && guard < 2 * HT * VT * CD + 8);
    n_chk++;
    if (!(last_tick && last_h == h && last_v == v))
      $display("FAIL advance_to timeout: got h=%0d v=%0d, wanted h=%0d v=%0d", last_h, last_v, h, v);
    else n_pass++;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    mcx   = 0;
    mcy   = 0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.cam_x  = '0;
    bus.cam_y  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus.hsync !== 1'b1) $display("FAIL reset hsync got %b exp 1", bus.hsync); else n_pass++;
    n_chk++; if (bus.vsync !== 1'b1) $display("FAIL reset vsync got %b exp 1", bus.vsync); else n_pass++;
    n_chk++; if (bus.video_on !== 1'b0) $display("FAIL reset video_on got %b exp 0", bus.video_on); else n_pass++;
    n_chk++; if (bus.map_on !== 1'b0) $display("FAIL reset map_on got %b exp 0", bus.map_on); else n_pass++;
    n_chk++; if (bus.map_x !== '0) $display("FAIL reset map_x got %0d exp 0", bus.map_x); else n_pass++;
    n_chk++; if (bus.map_y !== '0) $display("FAIL reset map_y got %0d exp 0", bus.map_y); else n_pass++;
    n_chk++; if (bus.pix_tick !== 1'b0) $display("FAIL reset pix_tick got %b exp 0", bus.pix_tick); else n_pass++;
    n_chk++; if (bus.frame_start !== 1'b0) $display("FAIL reset frame_start got %b exp 0", bus.frame_start); else n_pass++;
    release_reset();
  endtask

  task automatic test_strobe();
    int first = -1;
    for (int i = 0; i < 3 * CD; i++) begin
      advance();
      if (bus.pix_tick === 1'b1 && first < 0) first = cyc;
      n_chk++;
      if (bus.pix_tick !== last_tick)
        $display("FAIL strobe pix_tick cyc=%0d got %b exp %b", cyc, bus.pix_tick, last_tick);
      else n_pass++;
    end
    n_chk++;
    if (first != CD) $display("FAIL first_pix_tick got cycle %0d exp %0d", first, CD); else n_pass++;
  endtask

  task automatic test_scan_random(input int frames);
    for (int i = 0; i < frames * HT * VT * CD; i++) begin
      advance();
      if ($urandom_range(0, 39) == 0) bus.cam_x = PW'($urandom_range(0, 20));
      if ($urandom_range(0, 39) == 0) bus.cam_y = PW'($urandom);
      n_chk++;
      if (bus.pix_tick !== last_tick)
        $display("FAIL scan pix_tick cyc=%0d got %b exp %b", cyc, bus.pix_tick, last_tick);
      else n_pass++;
      if (last_tick) begin
        n_chk++;
        if ({bus.video_on, bus.hsync, bus.vsync, bus.map_on, bus.frame_start} !==
            {last_e.video_on, last_e.hsync, last_e.vsync, last_e.map_on, last_e.frame_start})
          $display("FAIL scan flags h=%0d v=%0d got vid/hs/vs/on/fs=%b%b%b%b%b exp %b%b%b%b%b",
                   last_h, last_v, bus.video_on, bus.hsync, bus.vsync, bus.map_on, bus.frame_start,
                   last_e.video_on, last_e.hsync, last_e.vsync, last_e.map_on, last_e.frame_start);
        else n_pass++;
        n_chk++;
        if (bus.map_x !== last_e.map_x)
          $display("FAIL scan map_x h=%0d v=%0d got %0d exp %0d", last_h, last_v, bus.map_x, last_e.map_x);
        else n_pass++;
        n_chk++;
        if (bus.map_y !== last_e.map_y)
          $display("FAIL scan map_y h=%0d v=%0d got %0d exp %0d", last_h, last_v, bus.map_y, last_e.map_y);
        else n_pass++;
      end
    end
  endtask

  task automatic test_cam_latch();
    bus.cam_x = '0;
    bus.cam_y = '0;
    advance_to(0, VA);
    advance_to(0, 3);
    n_chk++; if (bus.map_x !== PW'(0)) $display("FAIL latch_before map_x got %0d exp 0", bus.map_x); else n_pass++;
    bus.cam_x = PW'(3);
    advance_to(0, 4);
    n_chk++; if (bus.map_x !== PW'(0)) $display("FAIL latch_midframe map_x got %0d exp 0", bus.map_x); else n_pass++;
    advance_to(0, 0);
    n_chk++; if (bus.map_x !== PW'(3)) $display("FAIL latch_after map_x got %0d exp 3", bus.map_x); else n_pass++;
    n_chk++; if (bus.map_on !== 1'b1) $display("FAIL latch_after map_on got %b exp 1", bus.map_on); else n_pass++;
    advance_to(8, 0);
    n_chk++; if (bus.map_on !== 1'b1) $display("FAIL map_edge_in map_on got %b exp 1", bus.map_on); else n_pass++;
    advance_to(9, 0);
    n_chk++; if (bus.map_on !== 1'b0) $display("FAIL map_edge_out map_on got %b exp 0", bus.map_on); else n_pass++;
    n_chk++; if (bus.map_x !== PW'(12)) $display("FAIL map_edge_out map_x got %0d exp 12", bus.map_x); else n_pass++;
  endtask

  task automatic test_wrap();
    bus.cam_x = PW'(MOD - 10);
    advance_to(0, 0);
    advance_to(9, 0);
    n_chk++; if (bus.map_x !== PW'(MOD - 1)) $display("FAIL wrap_h9 map_x got %0d exp %0d", bus.map_x, MOD - 1); else n_pass++;
    n_chk++; if (bus.map_on !== 1'b0) $display("FAIL wrap_h9 map_on got %b exp 0", bus.map_on); else n_pass++;
    advance_to(10, 0);
    n_chk++; if (bus.map_x !== PW'(0)) $display("FAIL wrap_h10 map_x got %0d exp 0", bus.map_x); else n_pass++;
    n_chk++; if (bus.map_on !== 1'b0) $display("FAIL wrap_h10 map_on got %b exp 0", bus.map_on); else n_pass++;
    n_chk++; if (bus.video_on !== 1'b1) $display("FAIL wrap_h10 video_on got %b exp 1", bus.video_on); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] exp_y0;
`ifdef MAP_Y_UP_EN
    exp_y0 = PW'(VA - 1);
`else
    exp_y0 = PW'(0);
`endif
    bus.cam_x = PW'(5);
    advance_to(0, VA);
    advance_to(8, 5);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.video_on !== 1'b0) $display("FAIL midreset video_on got %b exp 0", bus.video_on); else n_pass++;
    n_chk++; if (bus.map_x !== '0) $display("FAIL midreset map_x got %0d exp 0", bus.map_x); else n_pass++;
    n_chk++; if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1)
      $display("FAIL midreset syncs got %b%b exp 11", bus.hsync, bus.vsync); else n_pass++;
    bus.cam_x = PW'(7);
    @(posedge clk);
    release_reset();
    repeat (CD) advance();
    n_chk++; if (!(last_h == 0 && last_v == 0 && bus.pix_tick === 1'b1))
      $display("FAIL restart first_pixel got pix_tick %b exp 1", bus.pix_tick); else n_pass++;
    n_chk++; if (bus.map_x !== PW'(0)) $display("FAIL restart map_x got %0d exp 0", bus.map_x); else n_pass++;
    n_chk++; if (bus.map_y !== exp_y0) $display("FAIL restart map_y got %0d exp %0d", bus.map_y, exp_y0); else n_pass++;
    n_chk++; if (bus.video_on !== 1'b1) $display("FAIL restart video_on got %b exp 1", bus.video_on); else n_pass++;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    cyc       = 0;
    mcx       = 0;
    mcy       = 0;
    last_tick = 1'b0;
    last_h    = 0;
    last_v    = 0;
    last_e    = '0;
    test_reset();
    test_strobe();
    test_scan_random(3);
    test_cam_latch();
    test_wrap();
    test_reset_mid();
    test_scan_random(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
